// File: rtl/alu_muldiv.sv
// Single-issue execution unit: one-cycle RV32I ALU/branch compares and 33-cycle iterative RV32M
// multiply/divide, broadcasting {valid, value, tag} to the RS, LSB and ROB.
module alu_muldiv #(
   parameter int CALC_OP_L1_NUM_WIDTH = 5,
   parameter int ROB_SIZE_WIDTH       = 3
) (
   input  logic                            clk_in,
   input  logic                            rst_in,
   input  logic                            rdy_in,
   input  logic                            need_flush_in,
   input  logic                            rs2alu_ready,
   input  logic [CALC_OP_L1_NUM_WIDTH-1:0] rs2alu_op_L1,
   input  logic                            rs2alu_op_L2,
   input  logic [31:0]                     rs2alu_opr1,
   input  logic [31:0]                     rs2alu_opr2,
   input  logic [ROB_SIZE_WIDTH:0]         rs2alu_dependency,
   output logic                            alu_valid,
   output logic [31:0]                     alu_value,
   output logic [ROB_SIZE_WIDTH:0]         alu_dependency,
   output logic                            alu_busy_out
);

   // Handshake: an op is taken on an enabled edge with rs2alu_ready=1 only while alu_busy_out=0;
   // a result is presented for exactly one cycle with alu_valid=1 (held while rdy_in=0).

   typedef logic [CALC_OP_L1_NUM_WIDTH-1:0] op_t;

   localparam op_t OP_ADD    = op_t'(0);
   localparam op_t OP_SLL    = op_t'(1);
   localparam op_t OP_SLT    = op_t'(2);
   localparam op_t OP_SLTU   = op_t'(3);
   localparam op_t OP_XOR    = op_t'(4);
   localparam op_t OP_SRL    = op_t'(5);
   localparam op_t OP_OR     = op_t'(6);
   localparam op_t OP_AND    = op_t'(7);
   localparam op_t OP_BEQ    = op_t'(8);
   localparam op_t OP_BNE    = op_t'(9);
   localparam op_t OP_BLT    = op_t'(10);
   localparam op_t OP_BGE    = op_t'(11);
   localparam op_t OP_BLTU   = op_t'(12);
   localparam op_t OP_BGEU   = op_t'(13);
   localparam op_t OP_MUL    = op_t'(16);
   localparam op_t OP_MULH   = op_t'(17);
   localparam op_t OP_MULHSU = op_t'(18);
   localparam op_t OP_MULHU  = op_t'(19);
   localparam op_t OP_DIV    = op_t'(20);
   localparam op_t OP_DIVU   = op_t'(21);
   localparam op_t OP_REM    = op_t'(22);
   localparam op_t OP_REMU   = op_t'(23);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   state_t                  state;
   logic [4:0]              cnt;
   op_t                     op_r;
   logic [ROB_SIZE_WIDTH:0] tag_r;
   logic                    neg_r;
   logic                    rem_neg_r;
   logic                    dz_r;
   logic [31:0]             mcand;
   logic [63:0]             prod;

   assign alu_busy_out = (state != ST_IDLE);

   // Single-cycle ALU and branch compare
   logic        lt_s, lt_u, eq;
   logic [4:0]  sh;
   logic [31:0] simple_res;

   assign lt_s = $signed(rs2alu_opr1) < $signed(rs2alu_opr2);
   assign lt_u = rs2alu_opr1 < rs2alu_opr2;
   assign eq   = rs2alu_opr1 == rs2alu_opr2;
   assign sh   = rs2alu_opr2[4:0];

   always_comb begin
      simple_res = 32'd0;
      case (rs2alu_op_L1)
         OP_ADD:  simple_res = rs2alu_op_L2 ? rs2alu_opr1 - rs2alu_opr2 : rs2alu_opr1 + rs2alu_opr2;
         OP_SLL:  simple_res = rs2alu_opr1 << sh;
         OP_SLT:  simple_res = {31'd0, lt_s};
         OP_SLTU: simple_res = {31'd0, lt_u};
         OP_XOR:  simple_res = rs2alu_opr1 ^ rs2alu_opr2;
         OP_SRL:  simple_res = rs2alu_op_L2 ? 32'($signed(rs2alu_opr1) >>> sh) : rs2alu_opr1 >> sh;
         OP_OR:   simple_res = rs2alu_opr1 | rs2alu_opr2;
         OP_AND:  simple_res = rs2alu_opr1 & rs2alu_opr2;
         OP_BEQ:  simple_res = {31'd0, eq};
         OP_BNE:  simple_res = {31'd0, !eq};
         OP_BLT:  simple_res = {31'd0, lt_s};
         OP_BGE:  simple_res = {31'd0, !lt_s};
         OP_BLTU: simple_res = {31'd0, lt_u};
         OP_BGEU: simple_res = {31'd0, !lt_u};
         default: simple_res = 32'd0;
      endcase
   end

   // Operand preparation for the iterative unit: work on magnitudes, fix signs at the end
   logic        is_mul, is_div, a_signed, b_signed, a_neg, b_neg;
   logic [31:0] mag_a, mag_b;

   assign is_mul   = (rs2alu_op_L1 >= OP_MUL) && (rs2alu_op_L1 <= OP_MULHU);
   assign is_div   = (rs2alu_op_L1 >= OP_DIV) && (rs2alu_op_L1 <= OP_REMU);
   assign a_signed = (rs2alu_op_L1 == OP_MULH) || (rs2alu_op_L1 == OP_MULHSU) ||
                     (rs2alu_op_L1 == OP_DIV)  || (rs2alu_op_L1 == OP_REM);
   assign b_signed = (rs2alu_op_L1 == OP_MULH) || (rs2alu_op_L1 == OP_DIV) ||
                     (rs2alu_op_L1 == OP_REM);
   assign a_neg    = a_signed && rs2alu_opr1[31];
   assign b_neg    = b_signed && rs2alu_opr2[31];
   assign mag_a    = a_neg ? -rs2alu_opr1 : rs2alu_opr1;
   assign mag_b    = b_neg ? -rs2alu_opr2 : rs2alu_opr2;

   // Shift-add step: prod = {partial_hi, remaining multiplier bits}
   logic [32:0] mul_sum;
   logic [63:0] mul_next;

   assign mul_sum  = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, mcand} : 33'd0);
   assign mul_next = {mul_sum, prod[31:1]};

   // Restoring divide step: prod = {remainder, dividend bits shifting into quotient}
   logic [32:0] div_shift;
   logic        div_ge;
   logic [63:0] div_next;

   assign div_shift = {prod[63:32], prod[31]};
   assign div_ge    = div_shift >= {1'b0, mcand};
   assign div_next  = div_ge ? {div_shift[31:0] - mcand, prod[30:0], 1'b1}
                             : {div_shift[31:0], prod[30:0], 1'b0};

   // Final sign fix and result selection
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix, long_res;

   assign prod_fix = neg_r ? -prod : prod;
   assign quot_fix = neg_r ? -prod[31:0] : prod[31:0];
   assign rem_fix  = rem_neg_r ? -prod[63:32] : prod[63:32];

   always_comb begin
      long_res = 32'd0;
      case (op_r)
         OP_MUL:                       long_res = prod_fix[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: long_res = prod_fix[63:32];
         OP_DIV, OP_DIVU:              long_res = dz_r ? 32'hFFFF_FFFF : quot_fix;
         OP_REM, OP_REMU:              long_res = rem_fix;
         default:                      long_res = 32'd0;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state          <= ST_IDLE;
         cnt            <= 5'd0;
         op_r           <= '0;
         tag_r          <= '1;
         neg_r          <= 1'b0;
         rem_neg_r      <= 1'b0;
         dz_r           <= 1'b0;
         mcand          <= 32'd0;
         prod           <= 64'd0;
         alu_valid      <= 1'b0;
         alu_value      <= 32'd0;
         alu_dependency <= '1;
      end else if (rdy_in) begin
         if (need_flush_in) begin
            state     <= ST_IDLE;
            alu_valid <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  alu_valid <= 1'b0;
                  if (rs2alu_ready) begin
                     if (is_mul || is_div) begin
                        op_r      <= rs2alu_op_L1;
                        tag_r     <= rs2alu_dependency;
                        neg_r     <= a_neg ^ b_neg;
                        rem_neg_r <= a_neg;
                        dz_r      <= (rs2alu_opr2 == 32'd0);
                        cnt       <= 5'd0;
                        mcand     <= is_mul ? mag_a : mag_b;
                        prod      <= {32'd0, is_mul ? mag_b : mag_a};
                        state     <= is_mul ? ST_MUL : ST_DIV;
                     end else begin
                        alu_valid      <= 1'b1;
                        alu_value      <= simple_res;
                        alu_dependency <= rs2alu_dependency;
                     end
                  end
               end
               ST_MUL, ST_DIV: begin
                  alu_valid <= 1'b0;
                  prod      <= (state == ST_MUL) ? mul_next : div_next;
                  cnt       <= cnt + 5'd1;
                  if (cnt == 5'd31) state <= ST_FIN;
               end
               ST_FIN: begin
                  alu_valid      <= 1'b1;
                  alu_value      <= long_res;
                  alu_dependency <= tag_r;
                  state          <= ST_IDLE;
               end
               default: begin
                  alu_valid <= 1'b0;
                  state     <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: directed and random ops checked against an arithmetic reference model,
// including latency, busy window, flush, stall and reset behaviour.
module tb_alu_muldiv;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic        need_flush_in = 1'b0;
   logic        rs2alu_ready = 1'b0;
   logic [4:0]  rs2alu_op_L1 = 5'd0;
   logic        rs2alu_op_L2 = 1'b0;
   logic [31:0] rs2alu_opr1 = 32'd0;
   logic [31:0] rs2alu_opr2 = 32'd0;
   logic [3:0]  rs2alu_dependency = 4'd0;
   logic        alu_valid;
   logic [31:0] alu_value;
   logic [3:0]  alu_dependency;
   logic        alu_busy_out;

   alu_muldiv #(
      .CALC_OP_L1_NUM_WIDTH(5),
      .ROB_SIZE_WIDTH      (3)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .need_flush_in    (need_flush_in),
      .rs2alu_ready     (rs2alu_ready),
      .rs2alu_op_L1     (rs2alu_op_L1),
      .rs2alu_op_L2     (rs2alu_op_L2),
      .rs2alu_opr1      (rs2alu_opr1),
      .rs2alu_opr2      (rs2alu_opr2),
      .rs2alu_dependency(rs2alu_dependency),
      .alu_valid        (alu_valid),
      .alu_value        (alu_value),
      .alu_dependency   (alu_dependency),
      .alu_busy_out     (alu_busy_out)
   );

   always #5 clk_in = ~clk_in;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic is_long(input logic [4:0] l1);
      return (l1 >= 5'd16) && (l1 <= 5'd23);
   endfunction

   // Reference model straight from the instruction definitions
   function automatic logic [31:0] model(input logic [4:0] l1, input logic l2,
                                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0]        p;
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (l1)
         5'd0:  return l2 ? a - b : a + b;
         5'd1:  return a << b[4:0];
         5'd2:  return (sa < sb) ? 32'd1 : 32'd0;
         5'd3:  return (a < b) ? 32'd1 : 32'd0;
         5'd4:  return a ^ b;
         5'd5:  return l2 ? 32'(sa >>> b[4:0]) : a >> b[4:0];
         5'd6:  return a | b;
         5'd7:  return a & b;
         5'd8:  return (a == b) ? 32'd1 : 32'd0;
         5'd9:  return (a != b) ? 32'd1 : 32'd0;
         5'd10: return (sa < sb) ? 32'd1 : 32'd0;
         5'd11: return (sa >= sb) ? 32'd1 : 32'd0;
         5'd12: return (a < b) ? 32'd1 : 32'd0;
         5'd13: return (a >= b) ? 32'd1 : 32'd0;
         5'd16: return a * b;
         5'd17: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
         5'd18: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
         5'd19: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
         5'd20: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         5'd22: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         5'd23: return (b == 32'd0) ? a : a % b;
         default: return 32'd0;
      endcase
   endfunction

   // Issue one op, wait for its result, check value, tag, latency and busy window.
   // stall_at>0 drops rdy_in for stall_len cycles starting that many cycles after accept.
   task automatic run_op(input string tag, input logic [4:0] l1, input logic l2,
                         input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag_id,
                         input int stall_at, input int stall_len);
      int          cycles, busy_cycles, exp_lat, exp_busy;
      logic [31:0] exp_v;
      exp_lat  = is_long(l1) ? 34 : 1;
      exp_busy = is_long(l1) ? 33 : 0;
      if (stall_at > 0) begin
         exp_lat  += stall_len;
         exp_busy += stall_len;
      end
      @(negedge clk_in);
      check({tag, " busy_before_issue"}, 32'(alu_busy_out), 32'd0);
      rs2alu_op_L1      = l1;
      rs2alu_op_L2      = l2;
      rs2alu_opr1       = a;
      rs2alu_opr2       = b;
      rs2alu_dependency = tag_id;
      rs2alu_ready      = 1'b1;
      exp_q.push_back(model(l1, l2, a, b));
      @(negedge clk_in);
      rs2alu_ready = 1'b0;
      rs2alu_opr1  = $urandom;
      rs2alu_opr2  = $urandom;
      cycles       = 1;
      busy_cycles  = 0;
      while (!alu_valid && cycles < 200) begin
         if (alu_busy_out) busy_cycles++;
         if (stall_at > 0 && cycles == stall_at) rdy_in = 1'b0;
         if (stall_at > 0 && cycles == stall_at + stall_len) rdy_in = 1'b1;
         @(negedge clk_in);
         cycles++;
      end
      rdy_in = 1'b1;
      exp_v  = exp_q.pop_front();
      check({tag, " valid"}, 32'(alu_valid), 32'd1);
      check({tag, " latency"}, 32'(cycles), 32'(exp_lat));
      check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
      check({tag, " busy_at_result"}, 32'(alu_busy_out), 32'd0);
      check({tag, " value"}, alu_value, exp_v);
      check({tag, " dep"}, 32'(alu_dependency), 32'(tag_id));
      @(negedge clk_in);
      check({tag, " valid_pulse"}, 32'(alu_valid), 32'd0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 40));
         4:       return -32'($urandom_range(1, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int          seen;
      logic [4:0]  rl1;
      logic [31:0] held;

      // Reset
      repeat (3) @(negedge clk_in);
      rst_in = 1'b0;
      check("reset valid", 32'(alu_valid), 32'd0);
      check("reset value", alu_value, 32'd0);
      check("reset dep", 32'(alu_dependency), 32'hF);
      check("reset busy", 32'(alu_busy_out), 32'd0);

      // Single-cycle ops
      run_op("add",   5'd0,  1'b0, 32'd5, 32'd7, 4'd3, 0, 0);
      run_op("sub",   5'd0,  1'b1, 32'd0, 32'd1, 4'd1, 0, 0);
      run_op("sra",   5'd5,  1'b1, 32'h8000_0000, 32'd4, 4'd2, 0, 0);
      run_op("srl",   5'd5,  1'b0, 32'h8000_0000, 32'd4, 4'd4, 0, 0);
      run_op("bltu",  5'd12, 1'b0, 32'd1, 32'd2, 4'd5, 0, 0);
      run_op("slt",   5'd2,  1'b0, 32'hFFFF_FFFF, 32'd1, 4'd6, 0, 0);
      run_op("bad14", 5'd14, 1'b0, 32'd9, 32'd9, 4'd7, 0, 0);

      // Multiply
      run_op("mulhu", 5'd19, 1'b0, 32'hFFFF_FFFF, 32'd3, 4'd0, 0, 0);
      run_op("mulh",  5'd17, 1'b0, 32'hFFFF_FFFF, 32'd3, 4'd1, 0, 0);
      run_op("mul",   5'd16, 1'b0, 32'hFFFF_FFFF, 32'd3, 4'd2, 0, 0);
      run_op("mulhsu", 5'd18, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 0, 0);

      // Divide special cases
      run_op("div_by0",  5'd20, 1'b0, 32'd7, 32'd0, 4'd4, 0, 0);
      run_op("remu_by0", 5'd23, 1'b0, 32'd7, 32'd0, 4'd5, 0, 0);
      run_op("div_ovf",  5'd20, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd6, 0, 0);
      run_op("rem_ovf",  5'd22, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd7, 0, 0);
      run_op("div_neg",  5'd20, 1'b0, -32'd7, 32'd2, 4'd0, 0, 0);
      run_op("rem_neg",  5'd22, 1'b0, -32'd7, 32'd2, 4'd1, 0, 0);

      // Flush 10 cycles into a divide
      @(negedge clk_in);
      rs2alu_op_L1 = 5'd21; rs2alu_opr1 = 32'd100; rs2alu_opr2 = 32'd7;
      rs2alu_dependency = 4'd2; rs2alu_ready = 1'b1;
      @(negedge clk_in);
      rs2alu_ready = 1'b0;
      repeat (9) @(negedge clk_in);
      need_flush_in = 1'b1;
      @(negedge clk_in);
      need_flush_in = 1'b0;
      check("flush busy", 32'(alu_busy_out), 32'd0);
      check("flush valid", 32'(alu_valid), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (alu_valid) seen++;
      end
      check("flush no_result", 32'(seen), 32'd0);
      run_op("add_after_flush", 5'd0, 1'b0, 32'd20, 32'd22, 4'd3, 0, 0);

      // Flush in the same cycle as an issue discards the issue
      @(negedge clk_in);
      rs2alu_op_L1 = 5'd0; rs2alu_opr1 = 32'd1; rs2alu_opr2 = 32'd1;
      rs2alu_ready = 1'b1; need_flush_in = 1'b1;
      @(negedge clk_in);
      rs2alu_ready = 1'b0; need_flush_in = 1'b0;
      check("flush_issue valid", 32'(alu_valid), 32'd0);
      check("flush_issue busy", 32'(alu_busy_out), 32'd0);

      // rdy_in low 5 cycles mid-multiply
      run_op("mul_stall", 5'd16, 1'b0, 32'd12345, 32'd678, 4'd4, 10, 5);

      // rdy_in low while a result is valid holds it
      @(negedge clk_in);
      rs2alu_op_L1 = 5'd6; rs2alu_op_L2 = 1'b0; rs2alu_opr1 = 32'hF0F0_0000;
      rs2alu_opr2 = 32'h0000_0F0F; rs2alu_dependency = 4'd5; rs2alu_ready = 1'b1;
      @(negedge clk_in);
      rs2alu_ready = 1'b0;
      rdy_in = 1'b0;
      held = 32'hF0F0_0F0F;
      repeat (3) begin
         @(negedge clk_in);
         check("hold valid", 32'(alu_valid), 32'd1);
         check("hold value", alu_value, held);
      end
      rdy_in = 1'b1;
      @(negedge clk_in);
      check("hold release", 32'(alu_valid), 32'd0);

      // Reset mid-multiply
      @(negedge clk_in);
      rs2alu_op_L1 = 5'd16; rs2alu_opr1 = 32'd3; rs2alu_opr2 = 32'd5; rs2alu_ready = 1'b1;
      @(negedge clk_in);
      rs2alu_ready = 1'b0;
      repeat (5) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      check("midreset valid", 32'(alu_valid), 32'd0);
      check("midreset value", alu_value, 32'd0);
      check("midreset dep", 32'(alu_dependency), 32'hF);
      check("midreset busy", 32'(alu_busy_out), 32'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk_in);
         if (alu_valid) seen++;
      end
      check("midreset no_result", 32'(seen), 32'd0);

      // Random ops
      for (int i = 0; i < 40; i++) begin
         rl1 = 5'($urandom_range(0, 31));
         run_op($sformatf("rand%0d_op%0d", i, rl1), rl1, 1'($urandom_range(0, 1)),
                pick_operand(), pick_operand(), 4'($urandom_range(0, 7)), 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
